// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-facing signal bundle of the branch predictor / redirect controller.
// The slave modport is the predictor; the master modport is the pipeline and hazard unit.
interface branch_predict_ctrl_if;
   logic [31:0] PCD;
   logic [2:0]  BranchD;
   logic        StallD;
   logic        FlushEIn;
   logic [2:0]  BranchE;
   logic        isBranch;
   logic        PredTakenD;
   logic [1:0]  PCSrcE;
   logic        FlushD;
   logic        FlushE;
   logic [31:0] BranchCount;
   logic [31:0] MispredictCount;

   modport slave (
      input  PCD, BranchD, StallD, FlushEIn, BranchE, isBranch,
      output PredTakenD, PCSrcE, FlushD, FlushE, BranchCount, MispredictCount
   );

   modport master (
      output PCD, BranchD, StallD, FlushEIn, BranchE, isBranch,
      input  PredTakenD, PCSrcE, FlushD, FlushE, BranchCount, MispredictCount
   );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with Decode prediction, Execute
// resolution, PC redirect / flush generation and saturating performance counters.
module branch_predict_ctrl #(
   parameter int         INDEX_BITS = 6,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input logic                  clk,
   input logic                  rst,
   branch_predict_ctrl_if.slave bp
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      PCSRC_NONE = 2'b00,
      PCSRC_TGT  = 2'b01,
      PCSRC_PC4  = 2'b10
   } pcsrc_e;

   function automatic logic is_cond_branch(input logic [2:0] code);
      return (code != 3'b000) && (code != 3'b111);
   endfunction

   logic [1:0]            r_table [ENTRIES];
   logic                  r_valid_e;
   logic                  r_pred_taken_e;
   logic [INDEX_BITS-1:0] r_indx_e;
   logic [31:0]           r_branch_count;
   logic [31:0]           r_mispredict_count;

   logic [INDEX_BITS-1:0] w_indx_d;
   logic                  w_is_br_d;
   logic                  w_is_br_e;
   logic                  w_resolve_e;
   logic                  w_miss_taken;
   logic                  w_false_taken;
   logic                  w_mispred_e;
   logic                  w_pred_taken_d;
   logic [1:0]            w_ctr_d;
   logic [1:0]            w_ctr_e;
   logic [1:0]            w_ctr_next;
   pcsrc_e                w_pcsrc_e;
   logic                  w_unused;

   // Only the word-index bits of the Decode PC select an entry.
   assign w_indx_d = bp.PCD[INDEX_BITS+1:2];
   assign w_unused = ^{bp.PCD[31:INDEX_BITS+2], bp.PCD[1:0]};

   assign w_is_br_d = is_cond_branch(bp.BranchD);
   assign w_is_br_e = is_cond_branch(bp.BranchE);

   // Decode reads the registered table, so a same-cycle update is not bypassed.
   assign w_ctr_d = r_table[w_indx_d];
   assign w_ctr_e = r_table[r_indx_e];

   assign w_resolve_e   = r_valid_e & w_is_br_e;
   assign w_miss_taken  = w_resolve_e &  bp.isBranch & ~r_pred_taken_e;
   assign w_false_taken = w_resolve_e & ~bp.isBranch &  r_pred_taken_e;
   assign w_mispred_e   = w_miss_taken | w_false_taken;

   // An Execute redirect wins over any Decode prediction.
   assign w_pred_taken_d = w_is_br_d & w_ctr_d[1] & ~w_mispred_e;

   // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_pcsrc_e = PCSRC_NONE;
      if (w_miss_taken) begin
         w_pcsrc_e = PCSRC_TGT;
      end else if (w_false_taken) begin
         w_pcsrc_e = PCSRC_PC4;
      end
   end

   always_comb begin
      w_ctr_next = w_ctr_e;
      if (bp.isBranch) begin
         if (w_ctr_e != 2'b11) w_ctr_next = w_ctr_e + 2'b01;
      end else begin
         if (w_ctr_e != 2'b00) w_ctr_next = w_ctr_e - 2'b01;
      end
   end

   assign bp.PredTakenD      = w_pred_taken_d;
   assign bp.PCSrcE          = w_pcsrc_e;
   assign bp.FlushE          = w_mispred_e;
   assign bp.FlushD          = w_mispred_e | w_pred_taken_d;
   assign bp.BranchCount     = r_branch_count;
   assign bp.MispredictCount = r_mispredict_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid_e      <= 1'b0;
         r_pred_taken_e <= 1'b0;
         r_indx_e       <= '0;
      end else if (w_mispred_e || bp.FlushEIn) begin
         r_valid_e      <= 1'b0;
         r_pred_taken_e <= 1'b0;
         r_indx_e       <= '0;
      end else if (!bp.StallD) begin
         r_valid_e      <= w_is_br_d;
         r_pred_taken_e <= w_pred_taken_d;
         r_indx_e       <= w_indx_d;
      end
   end

   // NOTE: the counter table is reset on purpose: predictions must start from a known bias, so it stays in flops rather than RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_table[i] <= INIT_STATE;
         end
      end else if (w_resolve_e) begin
         r_table[r_indx_e] <= w_ctr_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (w_resolve_e && (r_branch_count != '1)) begin
            r_branch_count <= r_branch_count + 32'd1;
         end
         if (w_mispred_e && (r_mispredict_count != '1)) begin
            r_mispredict_count <= r_mispredict_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: hand-traced table states, redirects,
// flushes, stall/flush capture rules and asynchronous reset.
module tb_branch_predict_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   branch_predict_ctrl_if bp_if ();

   branch_predict_ctrl #(
      .INDEX_BITS (6),
      .INIT_STATE (2'b01)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] br_d, input logic [31:0] pc_d, input logic stall,
                        input logic flush_in, input logic [2:0] br_e, input logic is_br);
      bp_if.BranchD  = br_d;
      bp_if.PCD      = pc_d;
      bp_if.StallD   = stall;
      bp_if.FlushEIn = flush_in;
      bp_if.BranchE  = br_e;
      bp_if.isBranch = is_br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0);
      tick();

      // In reset with a branch in Decode: everything quiet.
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("rst_pred",  bp_if.PredTakenD, 0);
      check("rst_pcsrc", bp_if.PCSrcE, 0);
      check("rst_flushd", bp_if.FlushD, 0);
      check("rst_flushe", bp_if.FlushE, 0);
      check("rst_bc", bp_if.BranchCount, 0);
      check("rst_mc", bp_if.MispredictCount, 0);
      rst = 1'b1;

      // Test 1: weakly not-taken, resolves taken -> missed-taken redirect.
      check("t1_pred", bp_if.PredTakenD, 0);
      check("t1_flushd", bp_if.FlushD, 0);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t1_pcsrc", bp_if.PCSrcE, 1);
      check("t1_flushd_res", bp_if.FlushD, 1);
      check("t1_flushe_res", bp_if.FlushE, 1);
      tick();

      // Test 2: now 10 -> predicted taken; correct resolutions climb to 11.
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t1_bc", bp_if.BranchCount, 1);
      check("t1_mc", bp_if.MispredictCount, 1);
      check("t2_pred", bp_if.PredTakenD, 1);
      check("t2_flushd", bp_if.FlushD, 1);
      check("t2_flushe", bp_if.FlushE, 0);
      tick();
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t2_pcsrc", bp_if.PCSrcE, 0);
      check("t2_pred_collide", bp_if.PredTakenD, 1);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t2_pcsrc_sat", bp_if.PCSrcE, 0);
      tick();

      // Test 3: 11 -> 10 -> 01 on two false-taken resolutions.
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t2_bc", bp_if.BranchCount, 3);
      check("t2_mc", bp_if.MispredictCount, 1);
      check("t3_pred_11", bp_if.PredTakenD, 1);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b0);
      check("t3_pcsrc_a", bp_if.PCSrcE, 2);
      check("t3_flushe_a", bp_if.FlushE, 1);
      check("t3_flushd_a", bp_if.FlushD, 1);
      tick();
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t3_pred_10", bp_if.PredTakenD, 1);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b0);
      check("t3_pcsrc_b", bp_if.PCSrcE, 2);
      tick();
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t3_pred_01", bp_if.PredTakenD, 0);
      check("t3_mc", bp_if.MispredictCount, 3);
      tick();

      // Decrement saturation at 00: two correct not-taken resolutions.
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b001, 1'b0);
      check("sat0_pcsrc_a", bp_if.PCSrcE, 0);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b0);
      check("sat0_pcsrc_b", bp_if.PCSrcE, 0);
      tick();
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("sat0_pred", bp_if.PredTakenD, 0);
      check("sat0_bc", bp_if.BranchCount, 7);
      check("sat0_mc", bp_if.MispredictCount, 3);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b1);
      check("sat0_miss", bp_if.PCSrcE, 1);
      tick();

      // Test 4: train index 1 to 10, then squash its predicted-taken Decode.
      drive(3'b001, 32'h104, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t4_pred_i1", bp_if.PredTakenD, 0);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t4_train", bp_if.PCSrcE, 1);
      tick();
      drive(3'b001, 32'h200, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t4_pred_i0", bp_if.PredTakenD, 0);
      tick();
      drive(3'b001, 32'h104, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t4_pred_forced", bp_if.PredTakenD, 0);
      check("t4_pcsrc", bp_if.PCSrcE, 1);
      check("t4_flushd", bp_if.FlushD, 1);
      check("t4_flushe", bp_if.FlushE, 1);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t4_squashed_pcsrc", bp_if.PCSrcE, 0);
      check("t4_squashed_flushe", bp_if.FlushE, 0);
      tick();
      drive(3'b001, 32'h104, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t4_bc", bp_if.BranchCount, 10);
      check("t4_mc", bp_if.MispredictCount, 6);
      check("t4_pred_i1_kept", bp_if.PredTakenD, 1);
      tick();

      // Test 5: StallD holds E-side capture but not resolution.
      drive(3'b001, 32'h108, 1'b1, 1'b0, 3'b001, 1'b1);
      check("t5_pcsrc_a", bp_if.PCSrcE, 0);
      check("t5_pred_i2", bp_if.PredTakenD, 0);
      check("t5_flushd", bp_if.FlushD, 0);
      tick();
      drive(3'b001, 32'h108, 1'b1, 1'b0, 3'b001, 1'b1);
      check("t5_bc_stall", bp_if.BranchCount, 11);
      check("t5_pcsrc_held", bp_if.PCSrcE, 0);
      tick();
      drive(3'b001, 32'h108, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t5_bc_stall2", bp_if.BranchCount, 12);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t5_pcsrc_enter", bp_if.PCSrcE, 1);
      tick();

      // FlushEIn bubbles the Decode branch out of Execute.
      drive(3'b001, 32'h108, 1'b0, 1'b1, 3'b000, 1'b0);
      check("t5_pred_i2_10", bp_if.PredTakenD, 1);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b0);
      check("t5_flushin_pcsrc", bp_if.PCSrcE, 0);
      tick();

      // Test 6: bring index 0 back to 01, then collide read and update.
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t5_flushin_bc", bp_if.BranchCount, 13);
      check("t6_pred_10", bp_if.PredTakenD, 1);
      tick();
      drive(3'b000, 32'h0, 1'b0, 1'b0, 3'b001, 1'b0);
      check("t6_false", bp_if.PCSrcE, 2);
      tick();
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t6_pred_01", bp_if.PredTakenD, 0);
      tick();
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t6_collide_pred", bp_if.PredTakenD, 0);
      check("t6_collide_pcsrc", bp_if.PCSrcE, 1);
      tick();
      drive(3'b111, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t6_reserved", bp_if.PredTakenD, 0);
      drive(3'b001, 32'h100, 1'b0, 1'b0, 3'b000, 1'b0);
      check("t6_after_pred", bp_if.PredTakenD, 1);
      tick();

      // Asynchronous reset in the middle of a pending resolution.
      drive(3'b001, 32'h108, 1'b0, 1'b0, 3'b001, 1'b1);
      check("t6_pre_rst_bc", bp_if.BranchCount, 15);
      check("t6_pre_rst_mc", bp_if.MispredictCount, 9);
      check("t6_pre_rst_pred", bp_if.PredTakenD, 1);
      rst = 1'b0;
      #1;
      check("arst_bc", bp_if.BranchCount, 0);
      check("arst_mc", bp_if.MispredictCount, 0);
      check("arst_pred", bp_if.PredTakenD, 0);
      check("arst_pcsrc", bp_if.PCSrcE, 0);
      check("arst_flushd", bp_if.FlushD, 0);
      tick();
      rst = 1'b1;
      drive(3'b001, 32'h104, 1'b0, 1'b0, 3'b001, 1'b1);
      check("post_rst_pred_i1", bp_if.PredTakenD, 0);
      check("post_rst_pcsrc", bp_if.PCSrcE, 0);
      tick();
      check("post_rst_bc", bp_if.BranchCount, 0);
      check("post_rst_mc", bp_if.MispredictCount, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Dynamic branch predictor and flush/redirect controller for the 5-stage RV32I pipeline.
- Holds a direct-mapped table of 2-bit saturating counters, indexed by PC.
- In Decode it predicts conditional branches; the pipeline takes PCTargetD on a predicted-taken branch.
- In Execute it compares the prediction against the branch comparator's isBranch result. It then drives PC redirect and D/E flushes, updates the table and keeps performance counters.

Parameters:
INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries (64).
INIT_STATE, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
PCD  in  32  PC of the instruction in Decode.
BranchD  in  3  branch code in Decode: 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 reserved (treated as none).
StallD  in  1  hazard unit holds Decode this cycle.
FlushEIn  in  1  hazard unit inserts a bubble into Execute next cycle.
BranchE  in  3  branch code in Execute, same encoding as BranchD.
isBranch  in  1  actual outcome from the Execute-stage comparator.
PredTakenD  out  1  Decode predicts taken; PC mux selects PCTargetD.
PCSrcE  out  2  Execute redirect: 00 none, 01 to PCTargetE (missed taken), 10 to PCPlus4E (false taken).
FlushD  out  1  clear the F/D register next edge.
FlushE  out  1  clear the D/E register next edge.
BranchCount  out  32  resolved conditional branches.
MispredictCount  out  32  mispredicted conditional branches.

Behaviour:
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. A counter predicts taken when its MSB is 1.
- Indexing:
  - IndxD = PCD[INDEX_BITS+1:2].
  - IsBrD = (BranchD != 000) and (BranchD != 111). IsBrE is defined the same way from BranchE.
- Execute-side state: ValidE, PredTakenE and IndxE, registered internally.
  - If FlushE or FlushEIn: ValidE <= 0, PredTakenE <= 0, IndxE <= 0.
  - Else if !StallD: ValidE <= IsBrD, PredTakenE <= PredTakenD, IndxE <= IndxD.
  - Else: all three hold.
- Resolution (combinational): ResolveE = ValidE and IsBrE.
  - MissTaken = ResolveE and isBranch and !PredTakenE.
  - FalseTaken = ResolveE and !isBranch and PredTakenE.
  - MispredE = MissTaken or FalseTaken.
- Outputs (combinational):
  - PCSrcE = 01 on MissTaken, 10 on FalseTaken, otherwise 00.
  - PredTakenD = IsBrD and table[IndxD][1] and !MispredE. An Execute redirect overrides any Decode prediction.
  - FlushE = MispredE.
  - FlushD = MispredE or PredTakenD.
- Table update, on the rising edge when ResolveE:
  - isBranch = 1: counter at IndxE saturating-increments (11 stays 11).
  - isBranch = 0: counter saturating-decrements (00 stays 00).
  - Only one entry is written per cycle.
- Read/write collision (IndxD == IndxE in the same cycle): the Decode read returns the pre-update value. There is no bypass.
- Performance counters:
  - BranchCount increments on each edge with ResolveE.
  - MispredictCount increments on each edge with MispredE.
  - Both saturate at 32'hFFFF_FFFF.
- StallD during resolution: resolution and table update still occur. StallD affects only the D-to-E capture.
- Reset (rst low, asynchronous): every table entry <= INIT_STATE; ValidE, PredTakenE, IndxE <= 0; both counters <= 0.
  - Consequences: PCSrcE = 00, FlushE = 0, and FlushD = PredTakenD = 0 for INIT_STATE < 2.
  - Reset mid-operation discards any pending resolution; there is no partial update.
- Release: state leaves reset on the first rising edge after rst goes high.
- Latency:
  - Prediction is same-cycle in Decode.
  - Resolution and redirect are same-cycle in Execute.
  - Table update is visible to Decode reads on the following cycle.

Test Plan:
1. Reset, then BranchD = 001, PCD = 0x100 -> PredTakenD = 0, FlushD = 0. Next cycle BranchE = 001, isBranch = 1 -> PCSrcE = 01, FlushD = FlushE = 1; table[0] becomes 10; BranchCount = 1, MispredictCount = 1.
2. Repeat branch at 0x100 taken: second time PredTakenD = 1, FlushD = 1, and on resolution PCSrcE = 00, counter goes 10 -> 11. A third taken resolution keeps it at 11 (saturation).
3. Counter at 11, branch at 0x100 resolves not-taken -> PCSrcE = 10, FlushE = 1, counter 11 -> 10. A second not-taken -> 10 -> 01, and PredTakenD = 0 afterwards.
4. Mispredict in E while D holds a predicted-taken branch at a different index -> PredTakenD forced 0, PCSrcE nonzero; next cycle ValidE = 0, and no update is made for the squashed branch.
5. StallD = 1 with a branch in D while E resolves -> the E-side update happens; the D branch enters E only after StallD drops. FlushEIn = 1 -> next-cycle ValidE = 0 and no counter increments.
6. Collision: PCD = 0x100 and IndxE = 0 with old value 01, resolving taken -> PredTakenD = 0 this cycle, 1 next cycle. Separately, assert rst low mid-resolution -> all counters return to 0 and all entries return to 01 immediately, without waiting for a clock edge.
